text_overlay: RTL

- Sequential, parametrised text overlay for the VGA path.
- Holds its own character buffer (MAX_CHARS entries) loaded through a write port, with runtime integer scaling (x1/x2/x4/x8), blink and invert.
- Produces a registered per-pixel glyph bit with a fixed 2-cycle latency from x/y.
- Sits between the pixel-coordinate generator and the colour mux; glyph bits come from the existing char_rom.

---
 rtl/text_overlay_pkg.sv | 19 +
 rtl/text_overlay_if.sv | 22 ++
 rtl/char_rom.sv | 24 ++
 rtl/text_overlay_blink_timer.sv | 33 +++
 rtl/text_overlay.sv | 125 ++++++++++++
 5 files changed

// File: rtl/text_overlay_pkg.sv
// Shared display definitions for the text overlay.
// Contents: blank-character code, glyph height, scale-select encodings and an
// address-width helper that never returns zero.
package text_overlay_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int         GLYPH_H     = 8;

  localparam logic [1:0] SCALE_X1 = 2'd0;
  localparam logic [1:0] SCALE_X2 = 2'd1;
  localparam logic [1:0] SCALE_X4 = 2'd2;
  localparam logic [1:0] SCALE_X8 = 2'd3;

  // Width needed to address n entries, at least one bit.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/text_overlay_if.sv
// Character-buffer write bus for the text overlay.
// Signals: wr_en/wr_addr/wr_data write one character slot, len_we/len_in load
// the string length, clr blanks the whole buffer and zeroes the length.
// master: the host side that drives the bus; slave: the overlay.
interface text_overlay_if
  import text_overlay_pkg::*;
#(
  parameter int MAX_CHARS = 16
);
  localparam int AW = clog2_safe(MAX_CHARS);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          len_we;
  logic [AW:0]   len_in;
  logic          clr;

  modport master (output wr_en, wr_addr, wr_data, len_we, len_in, clr);
  modport slave  (input  wr_en, wr_addr, wr_data, len_we, len_in, clr);

endinterface

// File: rtl/char_rom.sv
// Character glyph ROM (combinational), 8 rows of up to 8 columns per glyph.
// Ports: code (ASCII), row (0 = top), col (0 = leftmost) -> pixel.
// Glyphs are 5 pixels wide in columns 0..4; codes without a glyph show a box.
module char_rom (
  input  logic [7:0] code,
  input  logic [2:0] row,
  input  logic [2:0] col,
  output logic       pixel
);
  logic [63:0] glyph;

  always_comb begin
    glyph = 64'hF888_8888_88F8_0000;
    case (code)
      8'h20:   glyph = 64'h0000_0000_0000_0000;
      8'h41:   glyph = 64'h2050_8888_F888_8800;
      8'h48:   glyph = 64'h8888_88F8_8888_8800;
      8'h49:   glyph = 64'h7020_2020_2020_7000;
      default: glyph = 64'hF888_8888_88F8_0000;
    endcase
    pixel = glyph[63 - (8 * int'(row) + int'(col))];
  end

endmodule

// File: rtl/text_overlay_blink_timer.sv
// Blink timer: counts frame_start pulses and toggles phase every
// BLINK_FRAMES frames. phase = 0 means text visible, 1 means hidden.
// Ports: clk, rst_n (async active-low), frame_start (1-cycle pulse), phase.
module blink_timer
  import text_overlay_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  output logic phase
);
  localparam int CW = clog2_safe(BLINK_FRAMES);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (frame_start) begin
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_overlay.sv
// Text overlay for the VGA path: character buffer, x1/x2/x4/x8 scaling,
// blink and invert, two registered stages from x/y to the outputs.
// Ports: clk, rst_n (async active-low), x/y pixel position, start_x/start_y
// box origin, scale_sel, wr (buffer write bus), blink_en, invert,
// frame_start, pixel_on (glyph bit), pixel_valid (pixel inside visible box).
module text_overlay
  import text_overlay_pkg::*;
#(
  parameter int MAX_CHARS    = 16,
  parameter int CHAR_W       = 6,
  parameter int COORD_W      = 10,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] start_x,
  input  logic [COORD_W-1:0] start_y,
  input  logic [1:0]         scale_sel,
  text_overlay_if.slave      wr,
  input  logic               blink_en,
  input  logic               invert,
  input  logic               frame_start,
  output logic               pixel_on,
  output logic               pixel_valid
);
  localparam int AW = clog2_safe(MAX_CHARS);
  localparam int W  = COORD_W + 4;
  localparam logic [AW:0] LEN_MAX = (AW + 1)'(MAX_CHARS);

  function automatic logic [AW:0] sat_len(input logic [AW:0] n);
    return (n > LEN_MAX) ? LEN_MAX : n;
  endfunction

  logic [7:0]  char_buf [MAX_CHARS];
  logic [AW:0] len_q;
  logic        blink_phase;

  // clr has priority and drops any write or length load in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CHARS; i++) char_buf[i] <= ASCII_SPACE;
      len_q <= '0;
    end else if (wr.clr) begin
      for (int i = 0; i < MAX_CHARS; i++) char_buf[i] <= ASCII_SPACE;
      len_q <= '0;
    end else begin
      if (wr.wr_en && (int'(wr.wr_addr) < MAX_CHARS)) char_buf[wr.wr_addr] <= wr.wr_data;
      if (wr.len_we) len_q <= sat_len(wr.len_in);
    end
  end

  blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .phase       (blink_phase)
  );

  // Box bounds are formed 4 bits wider than the coordinates so a box running
  // off the right/bottom edge is clipped instead of wrapping onto x=0/y=0.
  logic [W-1:0]       x_w, y_w, sx_w, sy_w, x_end, y_end;
  logic               in_box;
  logic [COORD_W-1:0] ux, idx_full;

  always_comb begin
    x_w      = W'(x);
    y_w      = W'(y);
    sx_w     = W'(start_x);
    sy_w     = W'(start_y);
    x_end    = sx_w + ((W'(len_q) * W'(CHAR_W)) << scale_sel);
    y_end    = sy_w + (W'(GLYPH_H) << scale_sel);
    in_box   = (x_w >= sx_w) && (x_w < x_end) && (y_w >= sy_w) && (y_w < y_end);
    ux       = (x - start_x) >> scale_sel;
    idx_full = ux / COORD_W'(CHAR_W);
  end

  // ---- stage 1 boundary: box test and glyph cell coordinates ----
  logic               vld_p1;
  logic [COORD_W-1:0] idx_p1;
  logic [2:0]         col_p1, row_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
      col_p1 <= '0;
      row_p1 <= '0;
    end else begin
      vld_p1 <= in_box;
      idx_p1 <= idx_full;
      col_p1 <= 3'(ux % COORD_W'(CHAR_W));
      row_p1 <= 3'((y - start_y) >> scale_sel);
    end
  end

  logic [7:0] code_p1;
  logic       glyph_p1, vis_p1;

  // idx < length also guarantees idx < MAX_CHARS, so the low bits address the buffer.
  always_comb begin
    code_p1 = (idx_p1 < COORD_W'(len_q)) ? char_buf[idx_p1[AW-1:0]] : ASCII_SPACE;
    vis_p1  = vld_p1 && (!blink_en || !blink_phase);
  end

  char_rom u_rom (
    .code  (code_p1),
    .row   (row_p1),
    .col   (col_p1),
    .pixel (glyph_p1)
  );

  // ---- stage 2 boundary: registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid <= 1'b0;
      pixel_on    <= 1'b0;
    end else begin
      pixel_valid <= vis_p1;
      pixel_on    <= vis_p1 && (glyph_p1 ^ invert);
    end
  end

endmodule
